// File: rtl/recognition_sequencer_pkg.sv
// Shared definitions for the digit-recognition frame controller:
// FSM state encoding, the "no digit" code and default raster limits.
package recog_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    EDGE  = 3'd2,
    REC   = 3'd3,
    HOLD  = 3'd4,
    CAPT  = 3'd5,
    CLEAR = 3'd6
  } state_e;

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  // Raster limits shared with the scan counter and the recognizer.
  localparam int unsigned H_LAST_DEF = 639;
  localparam int unsigned V_LAST_DEF = 479;

  // Last pixel of a frame: valid pixel at the bottom-right corner.
  function automatic logic is_eof(
    input logic       vld,
    input logic [9:0] row,
    input logic [9:0] col,
    input logic [9:0] row_last,
    input logic [9:0] col_last
  );
    return vld && (row == row_last) && (col == col_last);
  endfunction

endpackage

// File: rtl/recognition_sequencer_digit_stability_filter.sv
// Publishes a digit only after it has been captured STABLE_CNT times in a
// row. A "no digit" capture flags an error and breaks any running match.
module digit_stability_filter
  import recog_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  logic [3:0] d,
  output logic [3:0] digital,
  output logic       valid,
  output logic       err
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [3:0]       last_r;
  logic [3:0]       last_nx_s;
  logic             publish_s;
  logic             none_s;

  // Next match count / last digit and whether this capture completes a run.
  always_comb begin
    none_s    = (d == DIGIT_NONE);
    cnt_nx_s  = cnt_r;
    last_nx_s = last_r;
    publish_s = 1'b0;
    if (none_s) begin
      cnt_nx_s  = '0;
      last_nx_s = DIGIT_NONE;
    end else if (d == last_r) begin
      // Saturate at CNT_MAX; only the transition into CNT_MAX publishes.
      if (cnt_r != CNT_MAX) begin
        cnt_nx_s  = cnt_r + CNT_ONE;
        publish_s = ((cnt_r + CNT_ONE) == CNT_MAX);
      end else begin
        cnt_nx_s  = cnt_r;
        publish_s = 1'b0;
      end
    end else begin
      last_nx_s = d;
      cnt_nx_s  = CNT_ONE;
      publish_s = (CNT_ONE == CNT_MAX);
    end
  end

  // Filter state and registered one-cycle result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      last_r  <= DIGIT_NONE;
      digital <= DIGIT_NONE;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else if (sample) begin
      cnt_r   <= cnt_nx_s;
      last_r  <= last_nx_s;
      digital <= publish_s ? d : digital;
      valid   <= publish_s;
      err     <= none_s;
    end else begin
      cnt_r   <= cnt_r;
      last_r  <= last_r;
      digital <= digital;
      valid   <= 1'b0;
      err     <= 1'b0;
    end
  end

endmodule

// File: rtl/recognition_sequencer.sv
// Frame-level controller: alternates boundary and recognition passes,
// clears the recognizer between runs and feeds results to the stability
// filter. All control outputs are registered from the next state.
module recognition_sequencer
  import recog_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned H_LAST     = H_LAST_DEF,
  parameter int unsigned V_LAST     = V_LAST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iStart,
  input  logic       iStop,
  input  logic       iPixVld,
  input  logic [9:0] iRow,
  input  logic [9:0] iCol,
  input  logic       iEdgeFin,
  input  logic       iRecFin,
  input  logic [3:0] iDigital,
  output logic       oEdgeEn,
  output logic       oRecEn,
  output logic       oRecRst_n,
  output logic [3:0] oDigital,
  output logic       oValid,
  output logic       oErr,
  output logic       oBusy
);

  localparam logic [9:0] H_LAST_V = 10'(H_LAST);
  localparam logic [9:0] V_LAST_V = 10'(V_LAST);

  state_e state_r;
  state_e state_nx_s;
  logic   abort_r;
  logic   eof_s;
  logic   capt_stb_s;

  // Next-state logic; a stop from any active state routes through CLEAR.
  always_comb begin
    eof_s      = is_eof(iPixVld, iRow, iCol, V_LAST_V, H_LAST_V);
    state_nx_s = state_r;
    if ((state_r != IDLE) && iStop) begin
      state_nx_s = CLEAR;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = (iStart && !iStop) ? SYNC : IDLE;
        SYNC:    state_nx_s = eof_s ? EDGE : SYNC;
        EDGE:    state_nx_s = iEdgeFin ? REC : EDGE;
        REC:     state_nx_s = iRecFin ? HOLD : REC;
        HOLD:    state_nx_s = CAPT;
        CAPT:    state_nx_s = CLEAR;
        CLEAR:   state_nx_s = abort_r ? IDLE : SYNC;
        default: state_nx_s = IDLE;
      endcase
    end
    // iDigital is sampled on the edge entering CAPT, so the filter's
    // registered pulses are visible during the CAPT cycle itself.
    capt_stb_s = (state_r == HOLD) && (state_nx_s == CAPT);
  end

  // Remember that the current CLEAR was caused by a stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_r <= 1'b0;
    end else if ((state_r != IDLE) && iStop) begin
      abort_r <= 1'b1;
    end else if (state_r == CLEAR) begin
      abort_r <= 1'b0;
    end else begin
      abort_r <= abort_r;
    end
  end

  // State register and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      oEdgeEn   <= 1'b0;
      oRecEn    <= 1'b0;
      oRecRst_n <= 1'b1;
      oBusy     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      oEdgeEn   <= (state_nx_s == EDGE);
      oRecEn    <= (state_nx_s == REC);
      oRecRst_n <= (state_nx_s != CLEAR);
      oBusy     <= (state_nx_s != IDLE);
    end
  end

  digit_stability_filter #(
    .STABLE_CNT (STABLE_CNT)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .sample  (capt_stb_s),
    .d       (iDigital),
    .digital (oDigital),
    .valid   (oValid),
    .err     (oErr)
  );

endmodule

// File: tb/tb_recognition_sequencer.sv
// Bench for recognition_sequencer on a small raster with random pixel gaps.
// Expected filter behaviour comes from an unbounded run-length model.
module tb_recognition_sequencer;
  import recog_pkg::*;

  localparam int STABLE = 3;
  localparam int HL     = 7;
  localparam int VL     = 5;
  localparam int FRAME  = (HL + 1) * (VL + 1);
  localparam int LIMIT  = 8 * FRAME;

  logic       clk = 1'b0;
  logic       rst, iStart, iStop, iPixVld, iEdgeFin, iRecFin;
  logic [9:0] iRow, iCol;
  logic [3:0] iDigital;
  logic       oEdgeEn, oRecEn, oRecRst_n, oValid, oErr, oBusy;
  logic [3:0] oDigital;

  always #5 clk = ~clk;

  recognition_sequencer #(
    .STABLE_CNT (STABLE),
    .H_LAST     (HL),
    .V_LAST     (VL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iStart    (iStart),
    .iStop     (iStop),
    .iPixVld   (iPixVld),
    .iRow      (iRow),
    .iCol      (iCol),
    .iEdgeFin  (iEdgeFin),
    .iRecFin   (iRecFin),
    .iDigital  (iDigital),
    .oEdgeEn   (oEdgeEn),
    .oRecEn    (oRecEn),
    .oRecRst_n (oRecRst_n),
    .oDigital  (oDigital),
    .oValid    (oValid),
    .oErr      (oErr),
    .oBusy     (oBusy)
  );

  int checks = 0;
  int errors = 0;
  int edge_pix = 0;
  int row_m = 0;
  int col_m = 0;
  bit stray = 1'b0;
  bit spur_edge = 1'b0;
  bit force_idle = 1'b0;

  // Reference model of the filter: plain run length of identical digits.
  int         run_len = 0;
  logic [3:0] run_digit = 4'hF;
  logic [3:0] exp_dig = 4'hF;
  logic       exp_valid = 1'b0;
  logic       exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present a pixel (random gap), flag fin on EOF if asked, advance.
  task automatic cycle(input int code, output bit eof);
    bit vld;
    vld      = force_idle ? 1'b0 : ($urandom_range(0, 3) != 0);
    eof      = vld && (row_m == VL) && (col_m == HL);
    iPixVld  = vld;
    iRow     = 10'(row_m);
    iCol     = 10'(col_m);
    iEdgeFin = ((code == 1) && eof) || spur_edge;
    iRecFin  = (code == 2) && eof;
    if (oEdgeEn === 1'b1 && vld) edge_pix++;
    @(posedge clk);
    #1;
    if (oValid !== 1'b0 || oErr !== 1'b0) stray = 1'b1;
    if (vld) begin
      if (col_m == HL) begin
        col_m = 0;
        row_m = (row_m == VL) ? 0 : row_m + 1;
      end else begin
        col_m++;
      end
    end
  endtask

  task automatic wait_frame(input int code, output bit eof);
    eof = 1'b0;
    for (int k = 0; k < LIMIT && !eof; k++) cycle(code, eof);
  endtask

  task automatic model_capture(input logic [3:0] d);
    exp_err = (d == 4'hF);
    if (d == 4'hF) begin
      run_len   = 0;
      run_digit = 4'hF;
    end else if (d == run_digit) begin
      run_len++;
    end else begin
      run_digit = d;
      run_len   = 1;
    end
    exp_valid = (d != 4'hF) && (run_len == STABLE);
    if (exp_valid) exp_dig = d;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_edge_en"}, oEdgeEn, 1'b0);
    check({tag, "_rec_en"}, oRecEn, 1'b0);
    check({tag, "_rec_rst_n"}, oRecRst_n, 1'b1);
    check({tag, "_digital"}, oDigital, 4'hF);
    check({tag, "_valid"}, oValid, 1'b0);
    check({tag, "_err"}, oErr, 1'b0);
    check({tag, "_busy"}, oBusy, 1'b0);
  endtask

  // One full SYNC/EDGE/REC/HOLD/CAPT/CLEAR round starting in SYNC.
  task automatic do_round(input logic [3:0] d, input bit start_in_rec, input bit rst_in_hold);
    bit e;
    edge_pix = 0;
    stray    = 1'b0;
    wait_frame(0, e);
    check("sync_eof", e, 1'b1);
    check("edge_en_on", oEdgeEn, 1'b1);
    check("edge_rec_en", oRecEn, 1'b0);
    check("edge_busy", oBusy, 1'b1);
    wait_frame(1, e);
    check("edge_fin_eof", e, 1'b1);
    check("edge_pix", edge_pix, FRAME);
    check("rec_edge_en", oEdgeEn, 1'b0);
    check("rec_en_on", oRecEn, 1'b1);
    iDigital = d;
    iStart   = start_in_rec;
    wait_frame(2, e);
    iStart = 1'b0;
    check("rec_fin_eof", e, 1'b1);
    check("hold_rec_en", oRecEn, 1'b0);
    check("hold_busy", oBusy, 1'b1);
    check("no_stray_pulse", stray, 1'b0);
    if (rst_in_hold) begin
      rst = 1'b1;
      cycle(0, e);
      rst = 1'b0;
      check_reset_values("rst_hold");
      run_len   = 0;
      run_digit = 4'hF;
      exp_dig   = 4'hF;
      return;
    end
    cycle(0, e);
    model_capture(d);
    check("capt_valid", oValid, exp_valid);
    check("capt_err", oErr, exp_err);
    check("capt_digital", oDigital, exp_dig);
    check("capt_rec_rst_n", oRecRst_n, 1'b1);
    cycle(0, e);
    check("clear_rec_rst_n", oRecRst_n, 1'b0);
    check("clear_valid", oValid, 1'b0);
    check("clear_busy", oBusy, 1'b1);
    cycle(0, e);
    check("sync_rec_rst_n", oRecRst_n, 1'b1);
    check("sync_busy", oBusy, 1'b1);
    check("sync_edge_en", oEdgeEn, 1'b0);
  endtask

  initial begin
    bit         e;
    int         sel;
    logic [3:0] rd;

    rst = 1'b1; iStart = 1'b0; iStop = 1'b0; iPixVld = 1'b0;
    iRow = 10'd0; iCol = 10'd0; iEdgeFin = 1'b0; iRecFin = 1'b0; iDigital = 4'hF;
    cycle(0, e);
    cycle(0, e);
    rst = 1'b0;
    check_reset_values("reset");

    // Start and stop together in IDLE: stop wins.
    iStart = 1'b1; iStop = 1'b1;
    cycle(0, e);
    iStart = 1'b0; iStop = 1'b0;
    check("start_stop_busy", oBusy, 1'b0);
    cycle(0, e);
    check("start_stop_busy2", oBusy, 1'b0);
    check("start_stop_edge", oEdgeEn, 1'b0);

    iStart = 1'b1;
    cycle(0, e);
    iStart = 1'b0;
    check("start_busy", oBusy, 1'b1);

    // Spurious boundary-finished in SYNC (no pixel, so no EOF) is ignored.
    force_idle = 1'b1; spur_edge = 1'b1;
    cycle(0, e);
    force_idle = 1'b0; spur_edge = 1'b0;
    check("spur_edge_en", oEdgeEn, 1'b0);
    check("spur_rec_en", oRecEn, 1'b0);
    check("spur_busy", oBusy, 1'b1);

    do_round(4'd7, 1'b0, 1'b0);
    do_round(4'd7, 1'b1, 1'b0);
    do_round(4'd7, 1'b0, 1'b0);
    do_round(4'd7, 1'b0, 1'b0);
    do_round(4'd7, 1'b0, 1'b0);
    do_round(4'd3, 1'b0, 1'b0);
    do_round(4'd3, 1'b0, 1'b0);
    do_round(4'd3, 1'b0, 1'b0);
    do_round(4'd5, 1'b0, 1'b0);
    do_round(4'hF, 1'b0, 1'b0);
    do_round(4'd5, 1'b0, 1'b0);
    do_round(4'd5, 1'b0, 1'b0);
    do_round(4'd5, 1'b0, 1'b0);

    // Stop in the middle of a recognition frame.
    wait_frame(0, e);
    check("stop_sync_eof", e, 1'b1);
    wait_frame(1, e);
    check("stop_rec_en", oRecEn, 1'b1);
    repeat (5) cycle(0, e);
    iStop = 1'b1;
    cycle(0, e);
    iStop = 1'b0;
    check("stop_rec_en_off", oRecEn, 1'b0);
    check("stop_rec_rst_n", oRecRst_n, 1'b0);
    check("stop_busy_clear", oBusy, 1'b1);
    cycle(0, e);
    check("stop_rec_rst_n_rel", oRecRst_n, 1'b1);
    check("stop_idle_busy", oBusy, 1'b0);
    stray = 1'b0;
    wait_frame(2, e);
    repeat (3) cycle(0, e);
    check("stop_no_capture", stray, 1'b0);
    check("stop_still_idle", oBusy, 1'b0);
    check("stop_digital_hold", oDigital, exp_dig);

    iStart = 1'b1;
    cycle(0, e);
    iStart = 1'b0;
    check("restart_busy", oBusy, 1'b1);
    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(0, 3);
      rd  = (sel == 0) ? 4'hF : ((sel == 1) ? 4'd9 : 4'd2);
      do_round(rd, 1'b0, 1'b0);
    end

    // Reset while in HOLD, then resume.
    do_round(4'd1, 1'b0, 1'b1);
    iStart = 1'b1;
    cycle(0, e);
    iStart = 1'b0;
    do_round(4'd8, 1'b0, 1'b0);
    do_round(4'd8, 1'b0, 1'b0);
    do_round(4'd8, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recognition_sequencer.md
# recognition_sequencer

Frame-level controller for the digit-recognition pipeline. It sits between the pixel scan counters and the boundary-finder / recognizer pair. It alternates frames between the boundary pass and the recognition pass, clears the recognizer's accumulators between runs, and samples the recognizer result. A stability filter then publishes a digit only after it has been seen on several consecutive recognition frames.

## Interface
Parameters:
- STABLE_CNT, 3: consecutive identical recognition results required before publishing (≥1)
- H_LAST, 639: last column address
- V_LAST, 479: last row address

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- iStart  in  1  level/pulse; begin continuous recognition (sampled in IDLE only)
- iStop  in  1  pulse; abort and return to IDLE
- iPixVld  in  1  iRow/iCol carry a valid pixel this cycle
- iRow  in  10  current pixel row address
- iCol  in  10  current pixel column address
- iEdgeFin  in  1  boundary finder reports last pixel processed
- iRecFin  in  1  recognizer reports last pixel processed
- iDigital  in  4  recognizer result, 4'hF = no digit
- oEdgeEn  out  1  enable for boundary finder
- oRecEn  out  1  enable for recognizer
- oRecRst_n  out  1  active-low clear to recognizer; one-cycle pulse
- oDigital  out  4  last published stable digit
- oValid  out  1  one-cycle pulse when oDigital is updated
- oErr  out  1  one-cycle pulse when a captured result is 4'hF
- oBusy  out  1  high in every state except IDLE

## Operation
- EOF means iPixVld && iRow==V_LAST && iCol==H_LAST.
- FSM states and transitions:
  - IDLE → SYNC on iStart.
  - SYNC → EDGE on EOF.
  - EDGE → REC on iEdgeFin.
  - REC → HOLD on iRecFin.
  - HOLD → CAPT after one cycle.
  - CAPT → CLEAR.
  - CLEAR → SYNC.
- Moore outputs:
  - oEdgeEn=1 only in EDGE.
  - oRecEn=1 only in REC.
  - oRecRst_n=0 only in CLEAR.
- EDGE starts on the pixel after EOF, so the first enabled pixel is (0,0). The iEdgeFin cycle is the last enabled pixel, and REC covers the whole next frame.
- HOLD is required because the recognizer result is registered one clock after its flags. CAPT samples iDigital exactly 2 cycles after the iRecFin cycle.
- iStop in any non-IDLE state forces CLEAR on the next cycle, then IDLE instead of SYNC. Enables drop in that same cycle. No capture occurs.
- iStart and iStop together in IDLE: stop wins, stay IDLE. iStart outside IDLE is ignored.
- Stability filter, evaluated only in CAPT with sampled value d:
  - d==4'hF: match count ← 0, last ← 4'hF, pulse oErr.
  - d==last: count ← min(count+1, STABLE_CNT).
  - Otherwise: last ← d, count ← 1.
  - oValid pulses and oDigital ← d when count transitions to STABLE_CNT. A continued stable run does not re-pulse.
  - With STABLE_CNT=1, every new non-F digit publishes.
- Count width is $clog2(STABLE_CNT+1). The count saturates and never wraps.
- oDigital holds across stop/start. Only rst clears it.

## Timing
- Reset values:
  - oEdgeEn=0, oRecEn=0, oRecRst_n=1.
  - oDigital=4'hF, oValid=0, oErr=0, oBusy=0.
  - FSM in IDLE, filter count 0, last=4'hF.
- All outputs are registered and change only on rising clk.
- Cycle sequence after start:
  - start → first EOF: SYNC.
  - Frame n: EDGE. Frame n+1: REC.
  - iRecFin+1: HOLD. iRecFin+2: CAPT, and oValid/oErr assert this cycle.
  - iRecFin+3: CLEAR. iRecFin+4: SYNC.
- Frame n+2 is skipped by the SYNC wait. Steady state is one result per 3 frames.
- iEdgeFin or iRecFin arriving outside its own state is ignored.
- rst mid-frame returns to the reset values next cycle. No CLEAR pulse is issued, because the recognizer has its own reset.

## Structure
- Package recog_pkg holds:
  - State enum: IDLE, SYNC, EDGE, REC, HOLD, CAPT, CLEAR.
  - DIGIT_NONE = 4'hF.
  - Default H_LAST/V_LAST constants, shared with the scan counter and recognizer.
- Sub-module digit_stability_filter (clk, rst, sample strobe, d, STABLE_CNT) owns last/count/oDigital/oValid/oErr. The FSM stays in the top level.

## Test plan
- Reset, then iStart, then three frames with iDigital=4'd7 at each capture, STABLE_CNT=3 → oValid single pulse at the third CAPT, oDigital=7. oEdgeEn high exactly 307200 pixels per EDGE frame.
- Captures 7,7,3,3,3 → no pulse until the fifth capture, then oDigital=3. The intermediate count resets to 1 on the 7→3 change.
- Capture 4'hF between two 5s → oErr pulse, count cleared, no oValid, oDigital unchanged.
- iStop mid-REC → oRecEn low next cycle, oRecRst_n low one cycle, FSM in IDLE, oBusy=0, no CAPT.
- iStart and iStop same cycle in IDLE → stays IDLE. iStart during REC → no effect on sequence.
- rst asserted in HOLD → all outputs at reset values next cycle, oDigital=4'hF. Spurious iEdgeFin in SYNC → ignored.
